matrix_tile_buffer: RTL and testbench

Parametrised matrix operand store for the multiplier datapath: a ROWS x COLS array of DATA_W-bit elements with one row/column-addressed write port, one random-access read port, and a streaming engine. The engine emits a whole row or a whole column (transposed access) over a valid/ready handshake. It feeds the multiply-accumulate array, where the A operand is consumed by row and the B operand by column. It supersedes the flat 16 x 32-bit single-port matrix memory.

---
 rtl/matrix_tile_buffer.sv | 256 +++++++++++++++++++++++++
 tb/tb_matrix_tile_buffer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_tile_buffer.sv
// -----------------------------------------------------------------------------
// matrix_tile_buffer
//
// Purpose:
//   Operand store for the multiply-accumulate array. Holds a ROWS x COLS matrix
//   of DATA_W-bit elements. It provides the following:
//     - one row/column-addressed write port,
//     - one random-access read port with one cycle of latency,
//     - a streaming engine that emits a whole row (the A operand) or a whole
//       column (the B operand, transposed access) over valid/ready.
//   Element (r, c) is stored at linear index r*COLS + c.
//
// Ports:
//   clk, rst_n        clock (rising edge) / asynchronous active-low reset
//   wr_en_i           write strobe; wr_row_i/wr_col_i/wr_data_i give the
//                     target element and its value. An out-of-range write is
//                     dropped.
//   rd_en_i           random read strobe; rd_row_i/rd_col_i give the element.
//   rd_data_o         read data, registered. It is 0 for an out-of-range index
//                     and holds its value while rd_en_i is low.
//   rd_valid_o        rd_data_o is valid this cycle.
//   stream_start_i    single-cycle request to stream row (stream_col_i = 0) or
//                     column (stream_col_i = 1) number stream_idx_i.
//   stream_busy_o     the stream engine is running.
//   s_data_o          stream element.
//   s_valid_o         s_data_o is valid.
//   s_ready_i         the consumer accepts s_data_o.
//   s_last_o          s_data_o is the final element of the stream.
// -----------------------------------------------------------------------------
module matrix_tile_buffer #(
   parameter int  DATA_W = 32,
   parameter int  ROWS   = 4,
   parameter int  COLS   = 4,
   localparam int RW     = $clog2(ROWS),
   localparam int CW     = $clog2(COLS),
   localparam int IW     = (RW > CW) ? RW : CW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en_i,
   input  logic [RW-1:0]     wr_row_i,
   input  logic [CW-1:0]     wr_col_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [RW-1:0]     rd_row_i,
   input  logic [CW-1:0]     rd_col_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_valid_o,
   input  logic              stream_start_i,
   input  logic              stream_col_i,
   input  logic [IW-1:0]     stream_idx_i,
   output logic              stream_busy_o,
   output logic [DATA_W-1:0] s_data_o,
   output logic              s_valid_o,
   input  logic              s_ready_i,
   output logic              s_last_o
);

   localparam int NE = ROWS * COLS;
   localparam int AW = $clog2(NE);

   // Bounds are one bit wider than the index so that ROWS/COLS themselves fit.
   localparam logic [RW:0]   ROWS_R   = (RW + 1)'(ROWS);
   localparam logic [CW:0]   COLS_C   = (CW + 1)'(COLS);
   localparam logic [IW:0]   ROWS_I   = (IW + 1)'(ROWS);
   localparam logic [IW:0]   COLS_I   = (IW + 1)'(COLS);
   localparam logic [IW-1:0] LAST_ROW = IW'(ROWS - 1);
   localparam logic [IW-1:0] LAST_COL = IW'(COLS - 1);
   localparam logic [IW-1:0] ONE_I    = IW'(1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   function automatic logic [AW-1:0] elem_addr(input logic [RW-1:0] row,
                                                input logic [CW-1:0] col);
      return AW'(int'(row) * COLS + int'(col));
   endfunction

   logic [DATA_W-1:0] mem_q [NE];

   logic              wr_ok_s;
   logic              rd_ok_s;
   logic [AW-1:0]     wr_addr_s;
   logic [AW-1:0]     rd_addr_s;
   logic [DATA_W-1:0] rd_data_d, rd_data_q;
   logic              rd_valid_d, rd_valid_q;

   state_t            state_d, state_q;
   logic              mode_d, mode_q;
   logic [IW-1:0]     idx_d, idx_q;
   logic [IW-1:0]     cnt_d, cnt_q;
   logic [DATA_W-1:0] s_data_d, s_data_q;
   logic              s_valid_d, s_valid_q;
   logic              s_last_d, s_last_q;

   logic              start_ok_s;
   logic              sel_col_s;
   logic [IW-1:0]     sel_idx_s;
   logic [IW-1:0]     sel_pos_s;
   logic [IW-1:0]     last_pos_s;
   logic [RW-1:0]     fetch_row_s;
   logic [CW-1:0]     fetch_col_s;
   logic [AW-1:0]     fetch_addr_s;
   logic [DATA_W-1:0] fetch_word_s;

   assign wr_ok_s   = wr_en_i && ({1'b0, wr_row_i} < ROWS_R) && ({1'b0, wr_col_i} < COLS_C);
   assign rd_ok_s   = ({1'b0, rd_row_i} < ROWS_R) && ({1'b0, rd_col_i} < COLS_C);
   assign wr_addr_s = elem_addr(wr_row_i, wr_col_i);
   assign rd_addr_s = elem_addr(rd_row_i, rd_col_i);

   // Element storage is written only, never reset.
   // The range check stops an out-of-range column from aliasing into the next row.
   always_ff @(posedge clk) begin
      if (wr_ok_s) begin
         mem_q[wr_addr_s] <= wr_data_i;
      end
   end

   // Random read next-state.
   // The read samples storage before this edge's write, so a collision returns old data.
   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      if (rd_en_i) begin
         rd_valid_d = 1'b1;
         if (rd_ok_s) begin
            rd_data_d = mem_q[rd_addr_s];
         end else begin
            rd_data_d = {DATA_W{1'b0}};
         end
      end else begin
         rd_valid_d = 1'b0;
      end
   end

   // Random read output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q  <= {DATA_W{1'b0}};
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign start_ok_s = stream_start_i &&
                       (stream_col_i ? ({1'b0, stream_idx_i} < COLS_I)
                                     : ({1'b0, stream_idx_i} < ROWS_I));
   assign last_pos_s = mode_q ? LAST_ROW : LAST_COL;

   // Fetch address selection.
   // In IDLE, element 0 of the requested stream is addressed directly from the inputs.
   // While streaming, element cnt+1 of the latched stream is addressed.
   always_comb begin
      if (state_q == ST_IDLE) begin
         sel_col_s = stream_col_i;
         sel_idx_s = stream_idx_i;
         sel_pos_s = {IW{1'b0}};
      end else begin
         sel_col_s = mode_q;
         sel_idx_s = idx_q;
         sel_pos_s = cnt_q + ONE_I;
      end
      if (sel_col_s) begin
         fetch_row_s = sel_pos_s[RW-1:0];
         fetch_col_s = sel_idx_s[CW-1:0];
      end else begin
         fetch_row_s = sel_idx_s[RW-1:0];
         fetch_col_s = sel_pos_s[CW-1:0];
      end
   end

   assign fetch_addr_s = elem_addr(fetch_row_s, fetch_col_s);
   assign fetch_word_s = mem_q[fetch_addr_s];

   // Stream FSM next-state and output datapath.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      s_data_d  = s_data_q;
      s_valid_d = s_valid_q;
      s_last_d  = s_last_q;
      case (state_q)
         ST_IDLE: begin
            if (start_ok_s) begin
               state_d   = ST_STREAM;
               mode_d    = stream_col_i;
               idx_d     = stream_idx_i;
               cnt_d     = {IW{1'b0}};
               s_data_d  = fetch_word_s;
               s_valid_d = 1'b1;
               // A stream has at least two elements, so element 0 is never last.
               s_last_d  = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_STREAM: begin
            // s_valid is always high in this state, so s_ready alone means an accept.
            if (s_ready_i) begin
               if (s_last_q) begin
                  state_d   = ST_IDLE;
                  s_valid_d = 1'b0;
                  s_last_d  = 1'b0;
               end else begin
                  cnt_d    = sel_pos_s;
                  s_data_d = fetch_word_s;
                  s_last_d = (sel_pos_s == last_pos_s);
               end
            end else begin
               state_d = ST_STREAM;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            s_valid_d = 1'b0;
            s_last_d  = 1'b0;
         end
      endcase
   end

   // Stream state registers.
   // The asynchronous reset aborts a stream in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         mode_q    <= 1'b0;
         idx_q     <= {IW{1'b0}};
         cnt_q     <= {IW{1'b0}};
         s_data_q  <= {DATA_W{1'b0}};
         s_valid_q <= 1'b0;
         s_last_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         s_data_q  <= s_data_d;
         s_valid_q <= s_valid_d;
         s_last_q  <= s_last_d;
      end
   end

   assign rd_data_o     = rd_data_q;
   assign rd_valid_o    = rd_valid_q;
   assign stream_busy_o = (state_q == ST_STREAM);
   assign s_data_o      = s_data_q;
   assign s_valid_o     = s_valid_q;
   assign s_last_o      = s_last_q;

endmodule

// File: tb/tb_matrix_tile_buffer.sv
// -----------------------------------------------------------------------------
// tb_matrix_tile_buffer
//
// Purpose:
//   Directed testbench for matrix_tile_buffer. It uses two instances:
//     - u_dut is a 4 x 4 matrix. It covers reset, the read table, the row and
//       column streams, collisions and reset during a stream.
//     - u_odd is a 4 x 3 matrix. A 4 x 4 matrix has 2-bit indices, so it
//       cannot express an out-of-range index. In u_odd, column 3 and column
//       stream 3 are out of range. An aliased write to (r,3) would land on
//       (r+1,0).
//
// Ports: none. The bench drives inputs on the falling clock edge and samples
// outputs just after a falling edge or 1 time unit after a rising edge.
// -----------------------------------------------------------------------------
module tb_matrix_tile_buffer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;

   logic        wr_en, rd_en, stream_start, stream_col, s_ready;
   logic [1:0]  wr_row, wr_col, rd_row, rd_col, stream_idx;
   logic [31:0] wr_data;
   logic [31:0] rd_data, s_data;
   logic        rd_valid, stream_busy, s_valid, s_last;

   logic        o_wr_en, o_rd_en, o_stream_start, o_stream_col, o_s_ready;
   logic [1:0]  o_wr_row, o_wr_col, o_rd_row, o_rd_col, o_stream_idx;
   logic [31:0] o_wr_data;
   logic [31:0] o_rd_data, o_s_data;
   logic        o_rd_valid, o_stream_busy, o_s_valid, o_s_last;

   int checks   = 0;
   int failures = 0;

   matrix_tile_buffer #(.DATA_W(32), .ROWS(4), .COLS(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en_i(wr_en), .wr_row_i(wr_row), .wr_col_i(wr_col), .wr_data_i(wr_data),
      .rd_en_i(rd_en), .rd_row_i(rd_row), .rd_col_i(rd_col),
      .rd_data_o(rd_data), .rd_valid_o(rd_valid),
      .stream_start_i(stream_start), .stream_col_i(stream_col), .stream_idx_i(stream_idx),
      .stream_busy_o(stream_busy), .s_data_o(s_data), .s_valid_o(s_valid),
      .s_ready_i(s_ready), .s_last_o(s_last)
   );

   matrix_tile_buffer #(.DATA_W(32), .ROWS(4), .COLS(3)) u_odd (
      .clk(clk), .rst_n(rst_n),
      .wr_en_i(o_wr_en), .wr_row_i(o_wr_row), .wr_col_i(o_wr_col), .wr_data_i(o_wr_data),
      .rd_en_i(o_rd_en), .rd_row_i(o_rd_row), .rd_col_i(o_rd_col),
      .rd_data_o(o_rd_data), .rd_valid_o(o_rd_valid),
      .stream_start_i(o_stream_start), .stream_col_i(o_stream_col), .stream_idx_i(o_stream_idx),
      .stream_busy_o(o_stream_busy), .s_data_o(o_s_data), .s_valid_o(o_s_valid),
      .s_ready_i(o_s_ready), .s_last_o(o_s_last)
   );

   typedef struct {
      logic        wr;
      logic [1:0]  wr_row;
      logic [1:0]  wr_col;
      logic [31:0] wr_data;
      logic        rd;
      logic [1:0]  rd_row;
      logic [1:0]  rd_col;
      logic        exp_valid;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [11];

   function automatic vec_t mk(input logic wr, input logic [1:0] wrr, input logic [1:0] wrc,
                               input logic [31:0] wd, input logic rd, input logic [1:0] rr,
                               input logic [1:0] rc, input logic ev, input logic [31:0] ed);
      vec_t v;
      v.wr = wr; v.wr_row = wrr; v.wr_col = wrc; v.wr_data = wd;
      v.rd = rd; v.rd_row = rr; v.rd_col = rc; v.exp_valid = ev; v.exp_data = ed;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic wr(input logic [1:0] r, input logic [1:0] c, input logic [31:0] d);
      wr_en = 1'b1; wr_row = r; wr_col = c; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic o_wr(input logic [1:0] r, input logic [1:0] c, input logic [31:0] d);
      o_wr_en = 1'b1; o_wr_row = r; o_wr_col = c; o_wr_data = d;
      @(negedge clk);
      o_wr_en = 1'b0;
   endtask

   task automatic o_rd(input logic [1:0] r, input logic [1:0] c, input logic [31:0] exp);
      o_rd_en = 1'b1; o_rd_row = r; o_rd_col = c;
      @(negedge clk);
      o_rd_en = 1'b0;
      chkb($sformatf("odd rd_valid(%0d,%0d)", r, c), o_rd_valid, 1'b1);
      chk($sformatf("odd rd_data(%0d,%0d)", r, c), o_rd_data, exp);
   endtask

   // Starts a stream and applies one s_ready bit per cycle from rdy.
   // While s_valid is high, k tracks which element should be on s_data.
   task automatic stream_run(input string nm, input logic col, input logic [1:0] idx,
                             input logic [3:0][31:0] exp, input logic [7:0] rdy, input int ncyc);
      int k;
      k = 0;
      stream_start = 1'b1; stream_col = col; stream_idx = idx; s_ready = 1'b0;
      @(negedge clk);
      stream_start = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         s_ready = rdy[c];
         #1;
         chkb($sformatf("%s c%0d s_valid", nm, c), s_valid, 1'b1);
         chk($sformatf("%s c%0d s_data", nm, c), s_data, exp[k]);
         chkb($sformatf("%s c%0d s_last", nm, c), s_last, (k == 3));
         chkb($sformatf("%s c%0d busy", nm, c), stream_busy, 1'b1);
         if (rdy[c]) k++;
         @(negedge clk);
      end
      s_ready = 1'b0;
      #1;
      chkb({nm, " end s_valid"}, s_valid, 1'b0);
      chkb({nm, " end s_last"}, s_last, 1'b0);
      chkb({nm, " end busy"}, stream_busy, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0][31:0] col2_exp;

      rst_n = 1'b0;
      wr_en = 1'b0; rd_en = 1'b0; stream_start = 1'b0; stream_col = 1'b0; s_ready = 1'b0;
      wr_row = 2'd0; wr_col = 2'd0; rd_row = 2'd0; rd_col = 2'd0; stream_idx = 2'd0;
      wr_data = 32'h0;
      o_wr_en = 1'b0; o_rd_en = 1'b0; o_stream_start = 1'b0; o_stream_col = 1'b0;
      o_s_ready = 1'b0;
      o_wr_row = 2'd0; o_wr_col = 2'd0; o_rd_row = 2'd0; o_rd_col = 2'd0;
      o_stream_idx = 2'd0; o_wr_data = 32'h0;

      vecs[0]  = mk(1'b0, 2'd0, 2'd0, 32'h0,    1'b1, 2'd2, 2'd3, 1'b1, 32'h203);
      vecs[1]  = mk(1'b0, 2'd0, 2'd0, 32'h0,    1'b0, 2'd0, 2'd0, 1'b0, 32'h203);
      vecs[2]  = mk(1'b0, 2'd0, 2'd0, 32'h0,    1'b1, 2'd0, 2'd0, 1'b1, 32'h000);
      vecs[3]  = mk(1'b0, 2'd0, 2'd0, 32'h0,    1'b1, 2'd3, 2'd1, 1'b1, 32'h301);
      vecs[4]  = mk(1'b1, 2'd3, 2'd3, 32'h1234, 1'b1, 2'd3, 2'd3, 1'b1, 32'h303);
      vecs[5]  = mk(1'b0, 2'd0, 2'd0, 32'h0,    1'b1, 2'd3, 2'd3, 1'b1, 32'h1234);
      vecs[6]  = mk(1'b1, 2'd3, 2'd0, 32'hCAFE, 1'b0, 2'd0, 2'd0, 1'b0, 32'h1234);
      vecs[7]  = mk(1'b0, 2'd0, 2'd0, 32'h0,    1'b1, 2'd3, 2'd0, 1'b1, 32'hCAFE);
      vecs[8]  = mk(1'b1, 2'd0, 2'd0, 32'hDEAD, 1'b1, 2'd0, 2'd0, 1'b1, 32'h000);
      vecs[9]  = mk(1'b0, 2'd0, 2'd0, 32'h0,    1'b1, 2'd0, 2'd0, 1'b1, 32'hDEAD);
      vecs[10] = mk(1'b0, 2'd0, 2'd0, 32'h0,    1'b1, 2'd1, 2'd2, 1'b1, 32'h102);

      // Outputs while held in reset and after release with no activity.
      #12;
      chk("rst rd_data", rd_data, 32'h0);
      chkb("rst rd_valid", rd_valid, 1'b0);
      chk("rst s_data", s_data, 32'h0);
      chkb("rst s_valid", s_valid, 1'b0);
      chkb("rst s_last", s_last, 1'b0);
      chkb("rst busy", stream_busy, 1'b0);
      chkb("rst odd s_valid", o_s_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle rd_data", rd_data, 32'h0);
      chkb("idle rd_valid", rd_valid, 1'b0);
      chk("idle s_data", s_data, 32'h0);
      chkb("idle s_valid", s_valid, 1'b0);
      chkb("idle s_last", s_last, 1'b0);
      chkb("idle busy", stream_busy, 1'b0);

      // 4x3 instance. Rows are filled from 3 down to 0, so an aliased
      // (r,3) write would overwrite (r+1,0) after that element was written.
      for (int r = 3; r >= 0; r--)
         for (int c = 0; c < 4; c++)
            o_wr(2'(r), 2'(c), 32'(256 * r + c));
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            o_rd(2'(r), 2'(c), 32'(256 * r + c));
      o_rd(2'd1, 2'd3, 32'h0);

      // Column 3 of a 3-column matrix: the request must be ignored.
      o_stream_start = 1'b1; o_stream_col = 1'b1; o_stream_idx = 2'd3;
      @(negedge clk);
      o_stream_start = 1'b0;
      chkb("odd bad idx s_valid", o_s_valid, 1'b0);
      chkb("odd bad idx busy", o_stream_busy, 1'b0);

      // Row 3, stalled, with a second start request while busy.
      o_stream_start = 1'b1; o_stream_col = 1'b0; o_stream_idx = 2'd3;
      @(negedge clk);
      chk("odd row3 first", o_s_data, 32'h300);
      chkb("odd row3 busy", o_stream_busy, 1'b1);
      o_stream_col = 1'b1; o_stream_idx = 2'd0;
      @(negedge clk);
      o_stream_start = 1'b0;
      chk("odd row3 after restart", o_s_data, 32'h300);
      chkb("odd row3 last0", o_s_last, 1'b0);
      o_s_ready = 1'b1;
      @(negedge clk);
      chk("odd row3 e1", o_s_data, 32'h301);
      chkb("odd row3 e1 last", o_s_last, 1'b0);
      @(negedge clk);
      chk("odd row3 e2", o_s_data, 32'h302);
      chkb("odd row3 e2 last", o_s_last, 1'b1);
      @(negedge clk);
      chkb("odd row3 done valid", o_s_valid, 1'b0);
      chkb("odd row3 done busy", o_stream_busy, 1'b0);
      o_s_ready = 1'b0;
      @(negedge clk);
      chkb("odd no late stream", o_s_valid, 1'b0);

      // 4x4 instance: fill with 0x100*r + c, then run the read table.
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            wr(2'(r), 2'(c), 32'(256 * r + c));
      for (int i = 0; i < 11; i++) begin
         wr_en = vecs[i].wr; wr_row = vecs[i].wr_row; wr_col = vecs[i].wr_col;
         wr_data = vecs[i].wr_data;
         rd_en = vecs[i].rd; rd_row = vecs[i].rd_row; rd_col = vecs[i].rd_col;
         @(posedge clk);
         #1;
         chkb($sformatf("vec%0d rd_valid", i), rd_valid, vecs[i].exp_valid);
         chk($sformatf("vec%0d rd_data", i), rd_data, vecs[i].exp_data);
         @(negedge clk);
      end
      wr_en = 1'b0; rd_en = 1'b0;

      // Row 1 with s_ready pattern 1,0,0,1,1,1, then column 2 at full rate
      // started in the cycle after busy falls.
      stream_run("row1", 1'b0, 2'd1, {32'h103, 32'h102, 32'h101, 32'h100}, 8'b0011_1001, 6);
      stream_run("col2", 1'b1, 2'd2, {32'h302, 32'h202, 32'h102, 32'h002}, 8'b0000_1111, 4);

      // Column 2 stalled on (0,2). Rewriting (0,2) must not disturb s_data.
      // The rewrite of (3,2) must reach the stream.
      stream_start = 1'b1; stream_col = 1'b1; stream_idx = 2'd2; s_ready = 1'b0;
      @(negedge clk);
      stream_start = 1'b0;
      chk("stall s_data", s_data, 32'h002);
      wr(2'd0, 2'd2, 32'h7777);
      chk("stall hold on rewrite", s_data, 32'h002);
      wr(2'd3, 2'd2, 32'hBEEF);
      col2_exp = {32'hBEEF, 32'h202, 32'h102, 32'h002};
      s_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("beef e%0d", k), s_data, col2_exp[k]);
         chkb($sformatf("beef e%0d last", k), s_last, (k == 3));
         @(negedge clk);
      end
      chkb("beef done valid", s_valid, 1'b0);
      s_ready = 1'b0;

      // Reset asserted while element 2 of row 2 is presented.
      stream_start = 1'b1; stream_col = 1'b0; stream_idx = 2'd2; s_ready = 1'b1;
      @(negedge clk);
      stream_start = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("pre-reset element 2", s_data, 32'h202);
      #2;
      rst_n = 1'b0;
      #1;
      chkb("mid-rst s_valid", s_valid, 1'b0);
      chkb("mid-rst s_last", s_last, 1'b0);
      chkb("mid-rst busy", stream_busy, 1'b0);
      chk("mid-rst s_data", s_data, 32'h0);
      s_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chkb("post-rst no resume", s_valid, 1'b0);
      stream_run("row2 after rst", 1'b0, 2'd2, {32'h203, 32'h202, 32'h201, 32'h200}, 8'b0000_1111, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
